// File: rtl/word_receiver_pkg.sv
// Shared UART framing constants and the word-assembly FSM encoding
// (package uart_pkg, also used by word_transmitter).
package uart_pkg;

    localparam int NB_BYTE        = 8;
    localparam int NB_DATA        = 32;
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } word_state_e;

endpackage : uart_pkg

// File: rtl/word_receiver_if.sv
// Byte-in / word-out bundle between the UART byte receiver, word_receiver
// and the debug/loader logic.
interface word_receiver_if #(
    parameter int NB_BYTE = 8,
    parameter int NB_DATA = 32
);
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_rx_32b_enable;
    logic               i_flush;
    logic [NB_BYTE-1:0] o_rx_byte;
    logic               o_rx_done_8b;
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_done_32b;
    logic [1:0]         o_byte_count;
    logic               o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_rx_32b_enable, i_flush,
        output o_rx_byte, o_rx_done_8b, o_rx_data, o_rx_done_32b,
               o_byte_count, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_done, i_rx_32b_enable, i_flush,
        input  o_rx_byte, o_rx_done_8b, o_rx_data, o_rx_done_32b,
               o_byte_count, o_timeout
    );
endinterface : word_receiver_if

// File: rtl/word_receiver_timeout.sv
// rx_timeout_counter: saturating idle counter with a terminal pulse on the
// last allowed cycle. Only used by word_receiver under WORD_RX_TIMEOUT_EN.
module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Idle counter: cleared on demand, holds at LAST instead of wrapping
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_terminal = i_enable && (r_count == LAST);

endmodule : rx_timeout_counter

// File: rtl/word_receiver.sv
// Packs received UART bytes into little-endian words while forwarding each
// byte. Optional partial-word timeout: define WORD_RX_TIMEOUT_EN.
module word_receiver
    import uart_pkg::*;
#(
    parameter int NB_DATA        = uart_pkg::NB_DATA,
    parameter int NB_BYTE        = uart_pkg::NB_BYTE,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic            i_clock,
    input  logic            i_reset,
    word_receiver_if.slave  bus
);
    localparam int BPW = NB_DATA / NB_BYTE;
    localparam int CW  = 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);

    word_state_e        r_state, w_next_state;
    logic [CW-1:0]      r_count, w_next_count;
    logic [NB_DATA-1:0] r_shift, w_next_shift, w_loaded;
    logic [NB_DATA-1:0] r_rx_data, w_next_data;
    logic [NB_BYTE-1:0] r_rx_byte;
    logic               r_done_8b, r_done_32b, r_timeout;
    logic               w_next_done_32b, w_next_timeout;
    logic               w_accept, w_terminal;

    assign w_accept = bus.i_rx_done && bus.i_rx_32b_enable && !bus.i_flush;

`ifdef WORD_RX_TIMEOUT_EN
    rx_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (w_accept || bus.i_flush || !bus.i_rx_32b_enable ||
                     (r_state != COLLECT)),
        .i_enable   (r_state == COLLECT),
        .o_terminal (w_terminal)
    );
`else
    assign w_terminal = 1'b0;
`endif

    // Shift register with the incoming byte dropped into lane r_count
    always_comb begin
        w_loaded = r_shift;
        for (int k = 0; k < BPW; k++) begin
            w_loaded[k*NB_BYTE +: NB_BYTE] = (r_count == CW'(k)) ?
                bus.i_rx_data : r_shift[k*NB_BYTE +: NB_BYTE];
        end
    end

    // Next state: disable beats flush beats byte beats timeout
    always_comb begin
        w_next_state    = r_state;
        w_next_count    = r_count;
        w_next_shift    = r_shift;
        w_next_data     = r_rx_data;
        w_next_done_32b = 1'b0;
        w_next_timeout  = 1'b0;
        if (!bus.i_rx_32b_enable) begin
            w_next_state = IDLE;
            w_next_count = '0;
            w_next_shift = '0;
        end else if (bus.i_flush) begin
            w_next_state = IDLE;
            w_next_count = '0;
        end else if (bus.i_rx_done) begin
            w_next_shift = w_loaded;
            if (r_count == LAST_IDX) begin
                w_next_data     = w_loaded;
                w_next_done_32b = 1'b1;
                w_next_count    = '0;
                w_next_state    = IDLE;
            end else begin
                w_next_count = r_count + CW'(1);
                w_next_state = COLLECT;
            end
        end else if (w_terminal) begin
            w_next_state   = IDLE;
            w_next_count   = '0;
            w_next_timeout = 1'b1;
        end else begin
            w_next_state = r_state;
        end
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_byte  <= '0;
            r_done_8b  <= 1'b0;
            r_done_32b <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_count    <= w_next_count;
            r_shift    <= w_next_shift;
            r_rx_data  <= w_next_data;
            r_rx_byte  <= bus.i_rx_done ? bus.i_rx_data : r_rx_byte;
            r_done_8b  <= bus.i_rx_done;
            r_done_32b <= w_next_done_32b;
            r_timeout  <= w_next_timeout;
        end
    end

    assign bus.o_rx_byte     = r_rx_byte;
    assign bus.o_rx_done_8b  = r_done_8b;
    assign bus.o_rx_data     = r_rx_data;
    assign bus.o_rx_done_32b = r_done_32b;
    assign bus.o_byte_count  = r_count;
    assign bus.o_timeout     = r_timeout;

endmodule : word_receiver

// File: tb/tb_word_receiver.sv
// Directed bench for word_receiver: vector table plus hand sequences for
// back-to-back bytes, reset mid-word and the timeout paths.
module tb_word_receiver;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clock = ~i_clock;

    word_receiver_if #(.NB_BYTE(8), .NB_DATA(32)) rx_if ();

    word_receiver #(
        .NB_DATA        (32),
        .NB_BYTE        (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (rx_if)
    );

    typedef struct {
        logic        en;
        logic        fl;
        logic [7:0]  b;
        logic        exp32;
        logic [31:0] word;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic en, input logic fl, input logic [7:0] b);
        @(posedge i_clock); #1;
        rx_if.i_rx_32b_enable = en;
        rx_if.i_flush         = fl;
        rx_if.i_rx_data       = b;
        rx_if.i_rx_done       = 1'b1;
        @(posedge i_clock); #1;
        rx_if.i_rx_done = 1'b0;
        rx_if.i_flush   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input string name);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tmp;
            tmp = w;
            send(1'b1, 1'b0, tmp[k*8 +: 8]);
        end
        check({name, "_done32"}, {31'd0, rx_if.o_rx_done_32b}, 32'd1);
        check({name, "_word"}, rx_if.o_rx_data, w);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h78, 1'b0, 32'h0000_0000, 2'd1};
        vecs[1]  = '{1'b1, 1'b0, 8'h56, 1'b0, 32'h0000_0000, 2'd2};
        vecs[2]  = '{1'b1, 1'b0, 8'h34, 1'b0, 32'h0000_0000, 2'd3};
        vecs[3]  = '{1'b1, 1'b0, 8'h12, 1'b1, 32'h1234_5678, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 32'h1234_5678, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'hBB, 1'b0, 32'h1234_5678, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'h01, 1'b0, 32'h1234_5678, 2'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'h02, 1'b0, 32'h1234_5678, 2'd2};
        vecs[8]  = '{1'b1, 1'b1, 8'h03, 1'b0, 32'h1234_5678, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 8'h11, 1'b0, 32'h1234_5678, 2'd1};
        vecs[10] = '{1'b1, 1'b0, 8'h22, 1'b0, 32'h1234_5678, 2'd2};
        vecs[11] = '{1'b1, 1'b0, 8'h33, 1'b0, 32'h1234_5678, 2'd3};
        vecs[12] = '{1'b1, 1'b0, 8'h44, 1'b1, 32'h4433_2211, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 8'h55, 1'b0, 32'h4433_2211, 2'd1};
        vecs[14] = '{1'b0, 1'b0, 8'h66, 1'b0, 32'h4433_2211, 2'd0};
        vecs[15] = '{1'b1, 1'b0, 8'hA1, 1'b0, 32'h4433_2211, 2'd1};
        vecs[16] = '{1'b1, 1'b0, 8'hA2, 1'b0, 32'h4433_2211, 2'd2};
        vecs[17] = '{1'b1, 1'b0, 8'hA3, 1'b0, 32'h4433_2211, 2'd3};
        vecs[18] = '{1'b1, 1'b0, 8'hA4, 1'b1, 32'hA4A3_A2A1, 2'd0};

        rx_if.i_rx_data       = 8'h00;
        rx_if.i_rx_done       = 1'b0;
        rx_if.i_rx_32b_enable = 1'b0;
        rx_if.i_flush         = 1'b0;

        repeat (3) @(posedge i_clock);
        #1;
        check("reset_outputs",
              {rx_if.o_rx_byte, rx_if.o_rx_done_8b, rx_if.o_rx_done_32b,
               rx_if.o_byte_count, rx_if.o_timeout, 19'd0}, 32'd0);
        check("reset_word", rx_if.o_rx_data, 32'd0);
        i_reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            send(vecs[i].en, vecs[i].fl, vecs[i].b);
            check($sformatf("v%0d_done8", i), {31'd0, rx_if.o_rx_done_8b}, 32'd1);
            check($sformatf("v%0d_byte", i), {24'd0, rx_if.o_rx_byte}, {24'd0, vecs[i].b});
            check($sformatf("v%0d_done32", i), {31'd0, rx_if.o_rx_done_32b}, {31'd0, vecs[i].exp32});
            check($sformatf("v%0d_word", i), rx_if.o_rx_data, vecs[i].word);
            check($sformatf("v%0d_count", i), {30'd0, rx_if.o_byte_count}, {30'd0, vecs[i].cnt});
            @(posedge i_clock); #1;
            check($sformatf("v%0d_pulse_end", i),
                  {30'd0, rx_if.o_rx_done_8b, rx_if.o_rx_done_32b}, 32'd0);
            repeat (8) @(posedge i_clock);
        end

        // back-to-back bytes on consecutive cycles
        @(posedge i_clock); #1;
        rx_if.i_rx_32b_enable = 1'b1;
        rx_if.i_rx_done       = 1'b1;
        rx_if.i_rx_data       = 8'h10;
        for (int k = 1; k < 4; k++) begin
            @(posedge i_clock); #1;
            check($sformatf("b2b_done8_%0d", k), {31'd0, rx_if.o_rx_done_8b}, 32'd1);
            check($sformatf("b2b_byte_%0d", k), {24'd0, rx_if.o_rx_byte}, 32'h10 + 32'(k - 1));
            rx_if.i_rx_data = 8'(8'h10 + k);
        end
        @(posedge i_clock); #1;
        rx_if.i_rx_done = 1'b0;
        check("b2b_done32", {31'd0, rx_if.o_rx_done_32b}, 32'd1);
        check("b2b_word", rx_if.o_rx_data, 32'h1312_1110);
        repeat (5) @(posedge i_clock);

        // reset in the middle of a word
        send(1'b1, 1'b0, 8'h5A);
        send(1'b1, 1'b0, 8'h5B);
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        @(posedge i_clock); #1;
        check("midrst_outputs",
              {rx_if.o_rx_byte, rx_if.o_rx_done_8b, rx_if.o_rx_done_32b,
               rx_if.o_byte_count, rx_if.o_timeout, 19'd0}, 32'd0);
        check("midrst_word", rx_if.o_rx_data, 32'd0);
        i_reset = 1'b1;
        send_word(32'hC4C3_C2C1, "midrst_clean");
        repeat (5) @(posedge i_clock);

`ifdef WORD_RX_TIMEOUT_EN
        send(1'b1, 1'b0, 8'hDE);
        repeat (99) @(posedge i_clock);
        #1;
        check("to_not_yet", {31'd0, rx_if.o_timeout}, 32'd0);
        @(posedge i_clock); #1;
        check("to_pulse", {31'd0, rx_if.o_timeout}, 32'd1);
        check("to_count", {30'd0, rx_if.o_byte_count}, 32'd0);
        @(posedge i_clock); #1;
        check("to_pulse_end", {31'd0, rx_if.o_timeout}, 32'd0);
        send_word(32'h0403_0201, "to_after");
        repeat (5) @(posedge i_clock);

        // byte lands exactly on the terminal cycle
        send(1'b1, 1'b0, 8'h77);
        repeat (98) @(posedge i_clock);
        send(1'b1, 1'b0, 8'h88);
        check("bnd_no_timeout", {31'd0, rx_if.o_timeout}, 32'd0);
        check("bnd_count", {30'd0, rx_if.o_byte_count}, 32'd2);
        @(posedge i_clock); #1;
        check("bnd_no_timeout_late", {31'd0, rx_if.o_timeout}, 32'd0);
`else
        send(1'b1, 1'b0, 8'hDE);
        repeat (150) @(posedge i_clock);
        #1;
        check("hold_count", {30'd0, rx_if.o_byte_count}, 32'd1);
        check("hold_no_timeout", {31'd0, rx_if.o_timeout}, 32'd0);
        send(1'b1, 1'b0, 8'h01);
        send(1'b1, 1'b0, 8'h02);
        send(1'b1, 1'b0, 8'h03);
        check("hold_done32", {31'd0, rx_if.o_rx_done_32b}, 32'd1);
        check("hold_word", rx_if.o_rx_data, 32'h0302_01DE);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_word_receiver

// File: doc/word_receiver.md
Name: word_receiver

Overview:
Assembles consecutive bytes from the UART byte receiver into 32-bit words, first byte received = least-significant byte. Sits between `receiver` (byte-level, `o_rx_done`/`o_data`) and the debug/loader logic. It is the receive-side counterpart of `word_transmitter` inside the UART top. Every byte is also forwarded individually, so 8-bit command traffic and 32-bit payload traffic share one path.

Parameters:
- NB_DATA, 32, assembled word width; must be a multiple of NB_BYTE.
- NB_BYTE, 8, byte width.
- TIMEOUT_CYCLES, 250000, idle clocks allowed between bytes of one word before the partial word is discarded (about 2.4 byte times at 9600 baud, 100 MHz).

Ports:
- i_clock  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_BYTE  byte from `receiver`; valid when i_rx_done=1.
- i_rx_done  in  1  single-cycle byte-received pulse.
- i_rx_32b_enable  in  1  1 = assemble words; 0 = byte-only mode.
- i_flush  in  1  discard any partial word.
- o_rx_byte  out  NB_BYTE  last received byte, registered.
- o_rx_done_8b  out  1  pulse, one per received byte.
- o_rx_data  out  NB_DATA  last completed word, held until the next word completes.
- o_rx_done_32b  out  1  pulse when a word completes.
- o_byte_count  out  2  bytes held in the current partial word (0..3).
- o_timeout  out  1  pulse when a partial word is dropped by timeout.

Behaviour:
- Reset (i_reset=0 at a clock edge): all outputs 0, byte counter 0, shift register 0, timeout counter 0, FSM in IDLE.
- FSM states are IDLE (count=0) and COLLECT (count 1..3). The byte index equals the count.
- Byte forwarding: on i_rx_done=1, o_rx_byte<=i_rx_data and o_rx_done_8b=1 on the next cycle, for exactly one cycle. This happens regardless of i_rx_32b_enable or i_flush.
- Assembly (i_rx_32b_enable=1, i_flush=0, i_rx_done=1):
  - The byte is written to lane [count*8 +: 8] and count is incremented.
  - IDLE goes to COLLECT on the first byte.
  - On the byte that makes count 4: o_rx_data<={b3,b2,b1,b0} and o_rx_done_32b=1 on the next cycle, coincident with that byte's o_rx_done_8b. Count returns to 0 and the FSM to IDLE.
- Latency: 1 clock from i_rx_done to both output pulses. Back-to-back i_rx_done pulses on consecutive cycles are accepted without loss.
- i_rx_32b_enable=0: count and shift register are forced to 0 (any partial word is discarded silently) and o_rx_done_32b is never asserted.
- i_flush=1: count<=0, FSM<=IDLE, timeout counter<=0.
  - If i_rx_done=1 in the same cycle, the byte is still forwarded on the 8b path but does not enter the word; flush wins.
- Timeout:
  - The counter runs only in COLLECT and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no byte that cycle: count<=0, FSM<=IDLE, o_timeout=1 for one cycle.
  - If a byte arrives on the terminal cycle, the byte wins: no timeout, and the byte is appended.
- o_rx_data is not cleared by flush, timeout or disable; only reset clears it.
- Counter width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Optional Feature:
- Macro: WORD_RX_TIMEOUT_EN.
- Defined: the timeout counter and o_timeout behave as described above.
- Undefined: no counter is instantiated, o_timeout is tied to 0, and a partial word is held indefinitely until it completes, is flushed, or is discarded by disable/reset.

Decomposition:
- Shared package uart_pkg holds:
  - NB_BYTE and NB_DATA constants.
  - BYTES_PER_WORD = NB_DATA/NB_BYTE.
  - FSM state typedef / encodings (IDLE, COLLECT), also reused by `word_transmitter`.
- One sub-module: rx_timeout_counter, with clear/enable/terminal-pulse, parameterised by TIMEOUT_CYCLES. It is instantiated only under WORD_RX_TIMEOUT_EN.

Test Plan:
- Word assembly: enable=1; bytes 0x78, 0x56, 0x34, 0x12 with gaps of 10 cycles -> four o_rx_done_8b pulses, o_rx_data=0x12345678, o_rx_done_32b asserted 1 cycle after the 4th i_rx_done, o_byte_count 1,2,3,0.
- Byte-only mode: enable=0; bytes 0xAA, 0xBB -> o_rx_byte=0xAA then 0xBB, o_rx_done_32b never asserted, o_byte_count stays 0, o_rx_data keeps its previous value.
- Flush: enable=1; send 0x01, 0x02; flush coincident with 0x03; then send 0x11, 0x22, 0x33, 0x44 -> 0x03 is forwarded on the 8b path only, and o_rx_data=0x44332211.
- Timeout (TIMEOUT_CYCLES=100, macro defined): send 0xDE, then idle 100 cycles -> o_timeout pulses once, o_byte_count=0; the next four bytes 0x01..0x04 yield 0x04030201.
- Timeout boundary: byte arrives exactly on the terminal cycle -> no o_timeout, o_byte_count increments.
- Reset mid-word: after 2 bytes assert i_reset=0 for 1 cycle -> all outputs 0; the next 4 bytes form a clean word.
